// File: rtl/decimal_pkg.sv
// Shared types for the decimal keypad front-end and the downstream encoder.
// Holds the digit count, the one-hot code type and the debouncer state encoding.
package decimal_pkg;

  localparam int NUM_DIGITS = 10;

  typedef logic [NUM_DIGITS-1:0] digit_onehot_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kd_state_t;

  function automatic logic is_onehot(input digit_onehot_t x);
    return $onehot(x);
  endfunction

  function automatic logic is_zero(input digit_onehot_t x);
    return (x == {NUM_DIGITS{1'b0}});
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, any width.
// Synchronous active-low reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // metastability stage followed by the resolved stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/decimal_key_debouncer.sv
// Synchronises, debounces and multi-key-filters 10 decimal key lines into a one-hot code.
// Optional auto-repeat of the press strobe while a key is held: define AUTO_REPEAT_EN.
module decimal_key_debouncer
  import decimal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] key_raw,
  output logic [NUM_DIGITS-1:0] key_onehot,
  output logic                  key_valid,
  output logic                  key_error
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);

  digit_onehot_t    key_sync_s;
  kd_state_t        state_r,  state_s;
  digit_onehot_t    cand_r,   cand_s;
  logic [CNT_W-1:0] cnt_r,    cnt_s;
  digit_onehot_t    onehot_r, onehot_s;
  logic             valid_r,  valid_s;
  logic             error_r,  error_s;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(32'd1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 32'sd1);
  logic [REP_W-1:0] rep_r, rep_s;
`endif

  sync_2ff #(
    .WIDTH(NUM_DIGITS)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (key_raw),
    .q    (key_sync_s)
  );

  // next-state and output decode; the mismatch test comes before count completion
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    onehot_s = onehot_r;
    valid_s  = 1'b0;
    error_s  = error_r;
`ifdef AUTO_REPEAT_EN
    rep_s    = rep_r;
`endif
    case (state_r)
      IDLE: begin
        if (is_onehot(key_sync_s)) begin
          cand_s  = key_sync_s;
          cnt_s   = CNT_ONE;
          state_s = DEBOUNCE;
        end else if (!is_zero(key_sync_s)) begin
          error_s = 1'b1;
        end else begin
          error_s = 1'b0;
        end
      end
      DEBOUNCE: begin
        if (key_sync_s != cand_r) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          onehot_s = cand_r;
          valid_s  = 1'b1;
          cnt_s    = CNT_ZERO;
          state_s  = PRESSED;
`ifdef AUTO_REPEAT_EN
          rep_s    = REP_ZERO;
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (is_zero(key_sync_s)) begin
          cnt_s   = CNT_ONE;
          state_s = RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_s   = REP_ZERO;
`endif
        end else if (key_sync_s != cand_r) begin
          error_s = 1'b1;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rep_r == REP_LAST) begin
            valid_s = 1'b1;
            rep_s   = REP_ZERO;
          end else begin
            rep_s = rep_r + REP_ONE;
          end
`else
          state_s = PRESSED;
`endif
        end
      end
      RELEASE: begin
        if (!is_zero(key_sync_s)) begin
          cnt_s   = CNT_ZERO;
          state_s = PRESSED;
`ifdef AUTO_REPEAT_EN
          rep_s   = REP_ZERO;
`endif
        end else if (cnt_r == CNT_LAST) begin
          onehot_s = {NUM_DIGITS{1'b0}};
          error_s  = 1'b0;
          cnt_s    = CNT_ZERO;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = CNT_ZERO;
        onehot_s = {NUM_DIGITS{1'b0}};
        error_s  = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cand_r   <= {NUM_DIGITS{1'b0}};
      cnt_r    <= CNT_ZERO;
      onehot_r <= {NUM_DIGITS{1'b0}};
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_r    <= REP_ZERO;
`endif
    end else begin
      state_r  <= state_s;
      cand_r   <= cand_s;
      cnt_r    <= cnt_s;
      onehot_r <= onehot_s;
      valid_r  <= valid_s;
      error_r  <= error_s;
`ifdef AUTO_REPEAT_EN
      rep_r    <= rep_s;
`endif
    end
  end

  assign key_onehot = onehot_r;
  assign key_valid  = valid_r;
  assign key_error  = error_r;

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Scoreboard bench for decimal_key_debouncer: a behavioural press/release model predicts
// the outputs every cycle, a negedge monitor compares; directed checks cover the key scenarios.
module tb_decimal_key_debouncer;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_raw;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_error;

  typedef struct packed {
    logic [9:0] code;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  always #5 clk = ~clk;

  decimal_key_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .key_onehot(key_onehot),
    .key_valid (key_valid),
    .key_error (key_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: 2-sample delay, then press/release tracking from stable-run lengths
  initial begin : model
    logic [9:0] d1, d2, s, cand, code;
    int         run, rep;
    logic       err, v;
    d1 = '0; d2 = '0; cand = '0; code = '0; run = 0; rep = 0; err = 1'b0;
    forever begin
      @(posedge clk);
      v = 1'b0;
      if (rst_n !== 1'b1) begin
        d1 = '0; d2 = '0; cand = '0; code = '0; run = 0; rep = 0; err = 1'b0;
      end else begin
        s  = d2;
        d2 = d1;
        d1 = key_raw;
        if (code == 10'd0) begin
          if (run == 0) begin
            if ($countones(s) == 1) begin
              cand = s;
              run  = 1;
            end else if (s != 10'd0) err = 1'b1;
            else err = 1'b0;
          end else if (s == cand) begin
            if (run == D - 1) begin
              code = cand; v = 1'b1; run = 0; rep = 0;
            end else run++;
          end else run = 0;
        end else begin
          if (run == 0) begin
            if (s == 10'd0) begin
              run = 1; rep = 0;
            end else if (s != code) err = 1'b1;
            else begin
`ifdef AUTO_REPEAT_EN
              if (rep == R - 1) begin
                v = 1'b1; rep = 0;
              end else rep++;
`endif
            end
          end else if (s == 10'd0) begin
            if (run == D - 1) begin
              code = 10'd0; err = 1'b0; run = 0;
            end else run++;
          end else begin
            run = 0; rep = 0;
          end
        end
      end
      exp_q.push_back({code, v, err});
    end
  end

  // Monitor: one expected entry per clock, compared on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_onehot", 32'(key_onehot), 32'(e.code));
        chk("sb_valid",  32'(key_valid),  32'(e.valid));
        chk("sb_error",  32'(key_error),  32'(e.err));
        chk("onehot0_invariant", 32'($onehot0(key_onehot)), 32'd1);
        if (key_valid === 1'b1) pulses++;
      end
    end
  end

  initial begin : stim
    int p0;
    int n;
    logic [9:0] code;
    rst_n   = 1'b0;
    key_raw = 10'h3FF;
    step(3);
    chk("reset_onehot", 32'(key_onehot), 32'd0);
    chk("reset_valid",  32'(key_valid),  32'd0);
    chk("reset_error",  32'(key_error),  32'd0);
    rst_n   = 1'b1;
    key_raw = 10'd0;
    step(8);
    chk("post_reset_no_pulse", 32'(pulses), 32'd0);

    // clean press: strobe exactly D+1 edges after the first edge seeing the key
    code    = 10'b0000100000;
    p0      = pulses;
    key_raw = code;
    repeat (D + 1) @(posedge clk);
    #1 chk("press_early_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1 chk("press_valid", 32'(key_valid), 32'd1);
    chk("press_code", 32'(key_onehot), 32'(code));
    @(negedge clk);
    step(3);
    key_raw = 10'd0;
    repeat (D + 1) @(posedge clk);
    #1 chk("release_hold", 32'(key_onehot), 32'(code));
    @(posedge clk);
    #1 chk("release_clear", 32'(key_onehot), 32'd0);
    @(negedge clk);
    step(4);
    chk("press_one_pulse", 32'(pulses - p0), 32'd1);

    // bounce on digit 3, then stable
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      key_raw = (i % 2 == 0) ? 10'b0000001000 : 10'd0;
      step(2);
    end
    step(8);
    chk("bounce_code", 32'(key_onehot), 32'h008);
    key_raw = 10'd0;
    step(10);
    chk("bounce_one_pulse", 32'(pulses - p0), 32'd1);

    // multi-key rejection
    p0      = pulses;
    key_raw = 10'b0000000011;
    step(6);
    chk("multi_error", 32'(key_error), 32'd1);
    chk("multi_code", 32'(key_onehot), 32'd0);
    key_raw = 10'd0;
    step(5);
    chk("multi_clear", 32'(key_error), 32'd0);
    chk("multi_no_pulse", 32'(pulses - p0), 32'd0);

    // second key while held
    key_raw = 10'b1000000000;
    step(8);
    key_raw = 10'b1000000001;
    step(5);
    chk("second_error", 32'(key_error), 32'd1);
    chk("second_code", 32'(key_onehot), 32'h200);
    key_raw = 10'd0;
    step(10);
    chk("second_clr_err", 32'(key_error), 32'd0);
    chk("second_clr_code", 32'(key_onehot), 32'd0);

`ifdef AUTO_REPEAT_EN
    p0      = pulses;
    key_raw = 10'b0010000000;
    step(D + 43);
    chk("repeat_pulses", 32'(pulses - p0), 32'd6);
    key_raw = 10'd0;
    step(10);
`endif

    // reset mid-press: no strobe may escape
    p0      = pulses;
    key_raw = 10'b0000000100;
    step(4);
    rst_n   = 1'b0;
    step(2);
    rst_n   = 1'b1;
    key_raw = 10'd0;
    step(8);
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);

    // randomized segments: idle, single digits, multi-key, short glitches
    for (int seg = 0; seg < 300; seg++) begin
      n = int'($urandom_range(9, 0));
      if (n == 0) key_raw = 10'd0;
      else if (n <= 6) key_raw = 10'd1 << $urandom_range(9, 0);
      else if (n == 7) key_raw = 10'($urandom_range(1023, 0));
      else key_raw = key_raw ^ (10'd1 << $urandom_range(9, 0));
      step(int'($urandom_range(12, 1)));
    end
    key_raw = 10'd0;
    step(12);
    chk("final_idle_code", 32'(key_onehot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
